// File: rtl/alu_leg_pkg.sv
// Shared types for the sequential LEG ALU: opcode/state enums and flag bit positions.
// Rotate opcodes are only decoded when the design is built with ALU_ROT_EN.
package alu_leg_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOT  = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_ASHR = 4'd7,
    OP_MUL  = 4'd8,
    OP_MULH = 4'd9,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11,
    OP_ROL  = 4'd12,
    OP_ROR  = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_iter_op(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_leg_muldiv_iter.sv
// One-bit-per-cycle unsigned multiplier (shift-add) and restoring divider.
// Operands are captured on start; done is high during the final iteration cycle.
module alu_leg_muldiv_iter
  import alu_leg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic               running_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  op_e                op_q;
  logic               mul_mode;
  logic               high_half;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     partial;
  logic [WIDTH-1:0]   diff;

  assign mul_mode  = (op_q == OP_MUL) || (op_q == OP_MULH);
  assign high_half = (op_q == OP_MULH) || (op_q == OP_REMU);
  assign acc_hi    = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo    = acc_q[WIDTH-1:0];

  // Divide by zero needs no special case: every trial subtract succeeds, so the
  // quotient fills with ones and the dividend shifts unchanged into the remainder.
  always_comb begin
    add_ext  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
    partial  = {acc_hi, acc_lo[WIDTH-1]};
    diff     = partial[WIDTH-1:0] - b_q;
    acc_step = acc_q;
    if (mul_mode)
      acc_step = {add_ext, acc_lo[WIDTH-1:1]};
    else if (partial >= {1'b0, b_q})
      acc_step = {diff, acc_lo[WIDTH-2:0], 1'b1};
    else
      acc_step = {partial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
  end

  assign done   = running_q && (cnt_q == CNT_LAST);
  assign result = high_half ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
  assign dz     = !mul_mode && (b_q == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_MUL;
    end else if (start) begin
      running_q <= 1'b1;
      cnt_q     <= '0;
      a_q       <= a;
      b_q       <= b;
      op_q      <= op;
      acc_q     <= ((op == OP_MUL) || (op == OP_MULH)) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
    end else if (running_q) begin
      acc_q <= acc_step;
      if (done) begin
        running_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_leg_seq.sv
// Sequential LEG ALU with valid/ready handshake, registered result and Z/N/C/V flags.
// Define ALU_ROT_EN to add the ROL/ROR opcodes; otherwise they decode as undecoded ops.
module alu_leg_seq
  import alu_leg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Input_1,
  input  logic [WIDTH-1:0] Input_2,
  input  logic [7:0]       Opcode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Output,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e           state_q;
  state_e           state_d;
  op_e              op;
  logic             accept;
  logic             iter_op;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic             iter_dz;
  logic [3:0]       iter_flags;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sc_result;
  logic [3:0]       sc_flags;
  logic             c_flag;
  logic             v_flag;
  logic             unused_opcode_hi;

  assign op               = op_e'(Opcode[3:0]);
  assign unused_opcode_hi = ^Opcode[7:4];
  assign iter_op          = is_iter_op(op);
  assign out_valid        = (state_q == DONE);
  assign in_ready         = (state_q != BUSY) && (!out_valid || out_ready);
  assign accept           = in_valid && in_ready;

`ifdef ALU_ROT_EN
  localparam logic [WIDTH-1:0] ROT_MOD = WIDTH'(WIDTH);
  logic [WIDTH-1:0]   rot_amt;
  logic [2*WIDTH-1:0] rot_dbl;
`endif

  always_comb begin
    sum_ext   = '0;
    sc_result = '0;
    c_flag    = 1'b0;
    v_flag    = 1'b0;
`ifdef ALU_ROT_EN
    rot_amt   = Input_2 % ROT_MOD;
    rot_dbl   = '0;
`endif
    case (op)
      OP_ADD: begin
        sum_ext   = {1'b0, Input_1} + {1'b0, Input_2};
        sc_result = sum_ext[WIDTH-1:0];
        c_flag    = sum_ext[WIDTH];
        v_flag    = (Input_1[WIDTH-1] == Input_2[WIDTH-1]) && (sum_ext[WIDTH-1] != Input_1[WIDTH-1]);
      end
      OP_SUB: begin
        sum_ext   = {1'b0, Input_1} + {1'b0, ~Input_2} + (WIDTH+1)'(1);
        sc_result = sum_ext[WIDTH-1:0];
        c_flag    = sum_ext[WIDTH];
        v_flag    = (Input_1[WIDTH-1] != Input_2[WIDTH-1]) && (sum_ext[WIDTH-1] != Input_1[WIDTH-1]);
      end
      OP_AND:  sc_result = Input_1 & Input_2;
      OP_OR:   sc_result = Input_1 | Input_2;
      OP_NOT:  sc_result = ~Input_1;
      OP_XOR:  sc_result = Input_1 ^ Input_2;
      OP_SHL:  sc_result = Input_1 << Input_2;
      OP_ASHR: sc_result = $signed(Input_1) >>> Input_2;
`ifdef ALU_ROT_EN
      OP_ROL: begin
        rot_dbl   = {Input_1, Input_1} << rot_amt;
        sc_result = rot_dbl[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        rot_dbl   = {Input_1, Input_1} >> rot_amt;
        sc_result = rot_dbl[WIDTH-1:0];
      end
`endif
      default: sc_result = '0;
    endcase
    sc_flags         = '0;
    sc_flags[FLAG_Z] = (sc_result == '0);
    sc_flags[FLAG_N] = sc_result[WIDTH-1];
    sc_flags[FLAG_C] = c_flag;
    sc_flags[FLAG_V] = v_flag;
  end

  always_comb begin
    iter_flags         = '0;
    iter_flags[FLAG_Z] = (iter_result == '0);
    iter_flags[FLAG_N] = iter_result[WIDTH-1];
    iter_flags[FLAG_V] = iter_dz;
  end

  alu_leg_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iter_op),
    .op     (op),
    .a      (Input_1),
    .b      (Input_2),
    .done   (iter_done),
    .result (iter_result),
    .dz     (iter_dz)
  );

  // An accept in DONE implies out_ready, so the old result retires as the new op starts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = iter_op ? BUSY : DONE;
      BUSY: if (iter_done) state_d = DONE;
      DONE: begin
        if (accept)         state_d = iter_op ? BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      Output  <= '0;
      flags   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !iter_op) begin
        Output <= sc_result;
        flags  <= sc_flags;
      end else if (iter_done) begin
        Output <= iter_result;
        flags  <= iter_flags;
      end
    end
  end

endmodule
